bsg_bypass_hold_arb: RTL
========================

# bsg_bypass_hold_arb

Round-robin arbiter that shares a single bypassable output slot between `num_req_p` requesters. The winner's word passes to the output in the same cycle (bypass). If downstream stalls, the word is captured in an enable-register and replayed until accepted. It sits in front of a shared downstream consumer and drives the enable/bypass select of the hold register itself.

## Interface
- `width_p`, default 16: data word width.
- `num_req_p`, default 4: number of requesters (≥2).
- `clk_i`  in  1  clock; all state on rising edge.
- `reset_i`  in  1  reset; one clock; reset is asynchronous and active-high.
- `v_i`  in  `num_req_p`  per-requester valid.
- `data_i`  in  `num_req_p`×`width_p`  per-requester data; slice k belongs to requester k.
- `yumi_o`  out  `num_req_p`  one-hot; word of requester k taken this cycle.
- `v_o`  out  1  output valid.
- `data_o`  out  `width_p`  output data.
- `ready_i`  in  1  downstream accepts when `v_o & ready_i`.

## Operation
- Two states: PASS and HELD. Reset enters PASS.
- **PASS:**
  - Round-robin pick among asserted `v_i`. The search starts at `last_r+1` and wraps mod `num_req_p`.
  - If any request exists: `v_o`=1 and `data_o` = winner's `data_i` (combinational bypass). `yumi_o[winner]`=1 regardless of `ready_i`.
  - `ready_i`=1: stay in PASS; hold register not written.
  - `ready_i`=0: write the winner's data into the hold register (enable=1); next state HELD.
  - No request: `v_o`=0, `yumi_o`=0, `data_o` don't-care, stay in PASS.
- **HELD:**
  - `v_o`=1, `data_o` = hold register, `yumi_o`=0 (no grants).
  - `ready_i`=1 → PASS; the next grant is made in the following cycle (one bubble).
  - `ready_i`=0 → stay in HELD; data stable.
- `last_r` updates to the winner index in every cycle where `yumi_o` is nonzero.
- Reset value of `last_r` = `num_req_p-1`, so requester 0 has first priority.
- Hold register is not reset; its content is don't-care after reset.
- Requester protocol:
  - `v_i` may drop without a grant.
  - `data_i[k]` must be stable while `v_i[k]`=1 and `yumi_o[k]`=0.
- Reset asserted mid-operation (including in HELD): state → PASS and `last_r` → `num_req_p-1` immediately. Any held word is discarded and never replayed.

## Timing
- While `reset_i`=1: `v_o`=0 and `yumi_o`=0 (asynchronous, no clock needed).
- Latency in PASS with `ready_i`=1: zero cycles, `data_i` → `data_o` combinationally.
- After a stall the word appears from the hold register starting the next cycle, until the cycle `ready_i`=1.
- Sustained throughput is one word/cycle with no stalls. Each stall episode costs one idle cycle after release.
- Grant path: `v_i`/`last_r` → `yumi_o`/`data_o` is combinational. `ready_i` affects only next state and the hold-register enable, never `yumi_o`.
- At most one `yumi_o` bit is set per cycle. It is never set in HELD.

## Structure
- The package holds the state enum (`e_pass`, `e_held`) and a `clog2`-based index width constant helper.
- Hold register: instantiate the existing `bsg_dff_en` (`width_p`) with the enable driven by `PASS & any_v & ~ready_i`.
- Arbitration goes in one sub-module, `bsg_arb_round_robin_ptr`: inputs are the request vector and `last_r`; outputs are the one-hot grant and the encoded index.
- The top module contains the FSM, `last_r`, and the output mux.

## Test plan
- Reset, then `v_i`=4'b0000 → `v_o`=0, `yumi_o`=0; assert `reset_i` with no clock edge → `v_o` falls immediately.
- After reset, `v_i`=4'b1111, `ready_i`=1 for 8 cycles → grants go to 0,1,2,3,0,1,2,3; `data_o` equals each winner's word in the same cycle.
- `v_i`=4'b0100, `data_i[2]`=16'hBEEF, `ready_i`=0 for 3 cycles, then 1:
  - Cycle 0: `yumi_o`=4'b0100, `data_o`=BEEF.
  - Cycles 1–3: `v_o`=1, `data_o`=BEEF, `yumi_o`=0.
  - Next cycle: bubble.
- Wrap-around: `last_r`=3, `v_i`=4'b1001 → grant 0; the next cycle with `v_i`=4'b1001 → grant 3.
- In HELD with word 16'h1234, assert `reset_i` → `v_o`=0; after release with `v_i`=0, 16'h1234 is never presented.
- `v_i[1]` pulses for 1 cycle while HELD → no `yumi_o[1]`, and no grant to 1 after the pulse.

Source files
------------

// File: rtl/bsg_bypass_hold_arb_pkg.sv
// Shared types and helpers for the bypass/hold round-robin arbiter.
package bsg_bypass_hold_arb_pkg;

    typedef enum logic {
        e_pass = 1'b0,
        e_held = 1'b1
    } state_e;

    // Width of an encoded requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin_ptr.sv
// Round-robin pick: search begins one past last_i and wraps around.
module bsg_arb_round_robin_ptr
    import bsg_bypass_hold_arb_pkg::*;
#(
    parameter int num_req_p = 4,
    localparam int idx_w    = idx_width(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [idx_w-1:0]     last_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [idx_w-1:0]     idx_o
);

    logic found;
    int   k;

    // First asserted request at offsets 1..num_req_p from the last winner.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 1; i <= num_req_p; i++) begin
            k = (int'(last_i) + i) % num_req_p;
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = idx_w'(k);
            end
        end
    end

endmodule

// File: rtl/bsg_dff_en.sv
// Enable register without reset; holds its value while en_i is low.
module bsg_dff_en #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // Capture on enable only.
    always_ff @(posedge clk_i) begin
        if (en_i) data_o <= data_i;
    end

endmodule

// File: rtl/bsg_bypass_hold_arb.sv
// Round-robin arbiter feeding one bypassable output slot with a replay
// register for downstream stalls.
module bsg_bypass_hold_arb
    import bsg_bypass_hold_arb_pkg::*;
#(
    parameter int width_p   = 16,
    parameter int num_req_p = 4,
    localparam int idx_w    = idx_width(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p-1:0][width_p-1:0] data_i,
    output logic [num_req_p-1:0]              yumi_o,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    input  logic                              ready_i
);

    state_e               state_r, state_n;
    logic [idx_w-1:0]     last_r;
    logic [num_req_p-1:0] grant;
    logic [idx_w-1:0]     win_idx;
    logic [width_p-1:0]   hold_data;
    logic                 hold_en;
    logic                 any_v;

    assign any_v = |v_i;

    bsg_arb_round_robin_ptr #(
        .num_req_p(num_req_p)
    ) arb (
        .req_i  (v_i),
        .last_i (last_r),
        .grant_o(grant),
        .idx_o  (win_idx)
    );

    bsg_dff_en #(
        .width_p(width_p)
    ) hold_reg (
        .clk_i (clk_i),
        .en_i  (hold_en),
        .data_i(data_i[win_idx]),
        .data_o(hold_data)
    );

    // State register; reset drops any held word by returning to PASS.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_pass;
        else         state_r <= state_n;
    end

    // Remember the last winner so the next search starts just past it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     last_r <= idx_w'(num_req_p - 1);
        else if (|yumi_o) last_r <= win_idx;
    end

    // Next state and outputs; reset forces the handshake outputs low
    // combinationally so they fall without waiting for a clock.
    always_comb begin
        state_n = state_r;
        v_o     = 1'b0;
        yumi_o  = '0;
        data_o  = hold_data;
        hold_en = 1'b0;
        case (state_r)
            e_pass: begin
                if (any_v) begin
                    v_o     = 1'b1;
                    yumi_o  = grant;
                    data_o  = data_i[win_idx];
                    hold_en = ~ready_i;
                    if (!ready_i) state_n = e_held;
                end
            end
            e_held: begin
                v_o = 1'b1;
                if (ready_i) state_n = e_pass;
            end
            default: state_n = e_pass;
        endcase
        if (reset_i) begin
            v_o     = 1'b0;
            yumi_o  = '0;
            hold_en = 1'b0;
        end
    end

endmodule
